// File: rtl/dht11_uart_frame.sv
// dht11_uart_frame: snapshots DHT11 ASCII digits and streams them as one text
// line ("T=+25.3 H=61.0%\r\n") over a valid/ready byte interface to a UART.
// A frame starts on a start pulse or on the periodic internal timer tick.
//
// Ports:
//   sys_clk, sys_rst_n         clock, asynchronous active-low reset
//   start                      single-cycle frame request
//   sign                       1 = negative temperature
//   temp_d3/d2/d1              temperature tens/units/tenths ASCII digits
//   hum_d3/d2/d1               humidity tens/units/tenths ASCII digits
//   tx_data, tx_valid          byte stream towards UART
//   tx_ready                   UART accepts byte
//   busy                       frame in progress (LOAD..DONE)
//   frame_done                 one-cycle pulse after the last byte is accepted
//
// Optional feature macro FRAME_CHECKSUM_EN: inserts two uppercase hex
// characters (XOR of the 15 body bytes) before CR LF, giving 19 bytes.
module dht11_uart_frame #(
  parameter int unsigned PERIOD_CYC = 50_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       start,
  input  logic       sign,
  input  logic [7:0] temp_d3,
  input  logic [7:0] temp_d2,
  input  logic [7:0] temp_d1,
  input  logic [7:0] hum_d3,
  input  logic [7:0] hum_d2,
  input  logic [7:0] hum_d1,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned IDX_W    = 5;
  localparam int unsigned SNAP_W   = 49;
  localparam int unsigned BODY_LEN = 15;
`ifdef FRAME_CHECKSUM_EN
  localparam int unsigned FRAME_LEN = 19;
`else
  localparam int unsigned FRAME_LEN = 17;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    index_q, index_d;
  logic                pending_q, pending_d;
  logic [SNAP_W-1:0]   snap_q, snap_d;
  logic [7:0]          tx_data_d;
  logic                tx_valid_d, busy_d, frame_done_d;
  logic [31:0]         timer_cnt;
  logic                timer_tick;
  logic                trigger;
  logic [7:0]          body_c  [BODY_LEN];
  logic [7:0]          frame_c [FRAME_LEN];

  // Non-digit characters are replaced by '?'.
  function automatic logic [7:0] digit(input logic [7:0] d);
    return (d >= 8'h30 && d <= 8'h39) ? d : 8'h3F;
  endfunction

  // Free-running period timer; PERIOD_CYC = 0 parks it at zero.
  assign timer_tick = (PERIOD_CYC != 0) && (timer_cnt == 32'(PERIOD_CYC - 1));
  assign trigger    = start | timer_tick;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                         timer_cnt <= '0;
    else if (timer_tick || PERIOD_CYC == 0) timer_cnt <= '0;
    else                                    timer_cnt <= timer_cnt + 32'd1;
  end

  // Text body "T=sTT.T H=HH.H%" built from the snapshot.
  always_comb begin
    body_c[0]  = 8'h54;
    body_c[1]  = 8'h3D;
    body_c[2]  = snap_q[48] ? 8'h2D : 8'h2B;
    body_c[3]  = digit(snap_q[47:40]);
    body_c[4]  = digit(snap_q[39:32]);
    body_c[5]  = 8'h2E;
    body_c[6]  = digit(snap_q[31:24]);
    body_c[7]  = 8'h20;
    body_c[8]  = 8'h48;
    body_c[9]  = 8'h3D;
    body_c[10] = digit(snap_q[23:16]);
    body_c[11] = digit(snap_q[15:8]);
    body_c[12] = 8'h2E;
    body_c[13] = digit(snap_q[7:0]);
    body_c[14] = 8'h25;
  end

`ifdef FRAME_CHECKSUM_EN
  logic [7:0] csum_c;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  always_comb begin
    csum_c = '0;
    for (int unsigned i = 0; i < BODY_LEN; i++) csum_c = csum_c ^ body_c[i];
  end
`endif

  // Full frame: body, optional checksum, CR LF.
  always_comb begin
    for (int unsigned i = 0; i < BODY_LEN; i++) frame_c[i] = body_c[i];
`ifdef FRAME_CHECKSUM_EN
    frame_c[BODY_LEN]     = hex_char(csum_c[7:4]);
    frame_c[BODY_LEN + 1] = hex_char(csum_c[3:0]);
`endif
    frame_c[FRAME_LEN - 2] = 8'h0D;
    frame_c[FRAME_LEN - 1] = 8'h0A;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    pending_d    = pending_q;
    snap_d       = snap_q;
    case (state_q)
      IDLE: if (trigger) state_d = LOAD;
      LOAD: begin
        snap_d  = {sign, temp_d3, temp_d2, temp_d1, hum_d3, hum_d2, hum_d1};
        index_d = '0;
        state_d = SEND;
        if (trigger) pending_d = 1'b1;
      end
      SEND: begin
        if (trigger) pending_d = 1'b1;
        if (tx_valid && tx_ready) begin
          if (index_q == LAST_IDX) state_d = DONE;
          else                     index_d = index_q + 5'd1;
        end
      end
      DONE: begin
        // A trigger arriving in DONE is served directly by the next LOAD.
        if (pending_q || trigger) state_d = LOAD;
        else                      state_d = IDLE;
        pending_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    busy_d       = (state_d != IDLE);
    tx_valid_d   = (state_d == SEND);
    frame_done_d = (state_d == DONE);
    tx_data_d    = tx_data;
    if (state_d == SEND) tx_data_d = frame_c[index_d];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      index_q    <= '0;
      pending_q  <= 1'b0;
      snap_q     <= '0;
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      pending_q  <= pending_d;
      snap_q     <= snap_d;
      tx_data    <= tx_data_d;
      tx_valid   <= tx_valid_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_dht11_uart_frame.sv
// Self-checking bench for dht11_uart_frame: directed frames, back-pressure,
// queuing/snapshot, mid-frame reset and periodic timer behaviour.
module tb_dht11_uart_frame;

`ifdef FRAME_CHECKSUM_EN
  localparam int LEN = 19;
`else
  localparam int LEN = 17;
`endif

  logic clk = 1'b0;
  logic rst_n, rst_t_n;
  logic start, start_t;
  logic sign;
  logic [7:0] temp_d3, temp_d2, temp_d1, hum_d3, hum_d2, hum_d1;
  logic [7:0] tx_data, tx_data_t;
  logic tx_valid, tx_valid_t, busy, busy_t, frame_done, frame_done_t;
  logic tx_ready;
  logic tx_ready_t = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int stalls   = 0;
  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];
  int done_t_q [$];
  logic pv = 1'b0, pr = 1'b0;
  logic [7:0] pd = 8'h00;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dht11_uart_frame #(.PERIOD_CYC(0)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(start), .sign(sign),
    .temp_d3(temp_d3), .temp_d2(temp_d2), .temp_d1(temp_d1),
    .hum_d3(hum_d3), .hum_d2(hum_d2), .hum_d1(hum_d1),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frame_done(frame_done)
  );

  dht11_uart_frame #(.PERIOD_CYC(100)) dut_t (
    .sys_clk(clk), .sys_rst_n(rst_t_n), .start(start_t), .sign(sign),
    .temp_d3(temp_d3), .temp_d2(temp_d2), .temp_d1(temp_d1),
    .hum_d3(hum_d3), .hum_d2(hum_d2), .hum_d1(hum_d1),
    .tx_data(tx_data_t), .tx_valid(tx_valid_t), .tx_ready(tx_ready_t),
    .busy(busy_t), .frame_done(frame_done_t)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Byte monitor: records accepted bytes, counts frame_done, checks stall hold.
  always @(negedge clk) begin
    if (tx_valid && tx_ready) got_q.push_back(tx_data);
    if (frame_done) done_cnt++;
    if (pv && !pr && rst_n) begin
      stalls++;
      check("stall_valid", 32'(tx_valid), 32'd1);
      check("stall_data", 32'(tx_data), 32'(pd));
    end
    pv = tx_valid;
    pr = tx_ready;
    pd = tx_data;
  end

  always @(negedge clk) if (frame_done_t) done_t_q.push_back(cyc);

  function automatic logic [7:0] san(input logic [7:0] d);
    return (d >= 8'h30 && d <= 8'h39) ? d : 8'h3F;
  endfunction

  task automatic set_in(input logic s, input logic [7:0] a, b, c, d, e, f);
    sign = s; temp_d3 = a; temp_d2 = b; temp_d1 = c;
    hum_d3 = d; hum_d2 = e; hum_d1 = f;
  endtask

  // Expected frame from the current inputs, appended to exp_q.
  task automatic build_exp();
    logic [7:0] b [$];
    logic [7:0] x;
    string h;
    b = '{8'h54, 8'h3D, (sign ? 8'h2D : 8'h2B), san(temp_d3), san(temp_d2), 8'h2E,
          san(temp_d1), 8'h20, 8'h48, 8'h3D, san(hum_d3), san(hum_d2), 8'h2E,
          san(hum_d1), 8'h25};
    x = 8'h00;
    foreach (b[i]) begin
      exp_q.push_back(b[i]);
      x = x ^ b[i];
    end
`ifdef FRAME_CHECKSUM_EN
    h = $sformatf("%02X", x);
    exp_q.push_back(h[0]);
    exp_q.push_back(h[1]);
`else
    h = "";
`endif
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic load_lit();
    string lit;
    lit = "T=+25.3 H=61.0%";
`ifdef FRAME_CHECKSUM_EN
    lit = {lit, "31"};
`endif
    lit = {lit, "\r\n"};
    for (int i = 0; i < lit.len(); i++) exp_q.push_back(lit[i]);
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check($sformatf("%s[%0d]", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input bit bp, input int budget);
    int i;
    i = 0;
    while (done_cnt < target && i < budget) begin
      tx_ready = bp ? (i % 3 == 0) : 1'b1;
      @(posedge clk); #1;
      i++;
    end
    check("done_in_time", 32'(done_cnt >= target), 32'd1);
    tx_ready = 1'b1;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int nv, idone, base, r, k, i;
    bit seen;
    rst_n = 1'b0; rst_t_n = 1'b0; start = 1'b0; start_t = 1'b0; tx_ready = 1'b1;
    set_in(1'b0, "2", "5", "3", "6", "1", "0");

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycles(3);
    check("idle_busy", 32'(busy), 32'd0);

    // Basic frame: latency, throughput, content
    got_q.delete(); exp_q.delete(); load_lit();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("load_busy", 32'(busy), 32'd1);
    check("load_valid", 32'(tx_valid), 32'd0);
    @(negedge clk);
    check("first_valid", 32'(tx_valid), 32'd1);
    check("first_byte", 32'(tx_data), 32'h54);
    nv = 1; seen = 1'b0; idone = -1;
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      if (frame_done) begin seen = 1'b1; idone = j; break; end
      if (tx_valid) nv++;
    end
    check("done_seen", 32'(seen), 32'd1);
    check("valid_cycles", 32'(nv), 32'(LEN));
    check("done_cycle", 32'(idone), 32'(LEN - 1));
    check("done_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("done_pulse", 32'(frame_done), 32'd0);
    check("after_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check_frame("basic");

    // Negative temperature and invalid digit
    set_in(1'b1, "2", 8'h41, "3", "6", "1", "0");
    got_q.delete(); exp_q.delete(); build_exp();
    base = done_cnt;
    pulse_start();
    wait_done(base + 1, 1'b0, 100);
    if (got_q.size() > 4) begin
      check("neg_sign", 32'(got_q[2]), 32'h2D);
      check("bad_digit", 32'(got_q[4]), 32'h3F);
    end
    check_frame("neg");

    // Back-pressure: ready 1-in-3
    set_in(1'b0, "2", "5", "3", "6", "1", "0");
    got_q.delete(); exp_q.delete(); load_lit();
    base = done_cnt; stalls = 0;
    pulse_start();
    wait_done(base + 1, 1'b1, 300);
    check("stalls_seen", 32'(stalls > 0), 32'd1);
    check_frame("bp");

    // Queuing and snapshot
    got_q.delete(); exp_q.delete(); build_exp();
    base = done_cnt;
    pulse_start();
    cycles(5);
    pulse_start();
    temp_d1 = "7";
    cycles(3);
    pulse_start();
    build_exp();
    seen = 1'b0;
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      if (frame_done) begin seen = 1'b1; break; end
    end
    check("q_first_done", 32'(seen), 32'd1);
    @(negedge clk);
    check("q_load_busy", 32'(busy), 32'd1);
    check("q_load_valid", 32'(tx_valid), 32'd0);
    @(negedge clk);
    check("q_second_T", 32'(tx_data), 32'h54);
    @(posedge clk); #1;
    wait_done(base + 2, 1'b0, 100);
    cycles(40);
    check("q_one_extra", 32'(done_cnt), 32'(base + 2));
    check_frame("queue");

    // Reset at byte 8
    got_q.delete();
    pulse_start();
    i = 0;
    while (got_q.size() < 8 && i < 100) begin @(posedge clk); #1; i++; end
    check("rst_at8", 32'(got_q.size()), 32'd8);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", 32'(tx_data), 32'h00);
    check("mid_rst_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(frame_done), 32'd0);
    cycles(2);
    rst_n = 1'b1;
    cycles(40);
    check("rst_no_bytes", 32'(got_q.size()), 32'd8);
    check("rst_idle", 32'(busy), 32'd0);
    got_q.delete(); exp_q.delete(); build_exp();
    base = done_cnt;
    pulse_start();
    wait_done(base + 1, 1'b0, 100);
    check_frame("post_rst");

    // Timer instance: PERIOD_CYC = 100
    r = cyc;
    rst_t_n = 1'b1;
    i = 0;
    while (done_t_q.size() < 2 && i < 400) begin @(posedge clk); #1; i++; end
    check("tmr_two", 32'(done_t_q.size() >= 2), 32'd1);
    if (done_t_q.size() >= 2) begin
      check("tmr_first", 32'(done_t_q[0]), 32'(r + 101 + LEN));
      check("tmr_period1", 32'(done_t_q[1] - done_t_q[0]), 32'd100);
      k = done_t_q[1] - LEN - 1;
      i = 0;
      while (cyc < k + 99 && i < 200) begin @(posedge clk); #1; i++; end
      start_t = 1'b1;
      @(posedge clk); #1;
      start_t = 1'b0;
      i = 0;
      while (done_t_q.size() < 4 && i < 400) begin @(posedge clk); #1; i++; end
      cycles(20);
      check("tmr_four", 32'(done_t_q.size()), 32'd4);
      if (done_t_q.size() >= 4) begin
        check("tmr_period2", 32'(done_t_q[2] - done_t_q[1]), 32'd100);
        check("tmr_period3", 32'(done_t_q[3] - done_t_q[2]), 32'd100);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dht11_uart_frame.md
# dht11_uart_frame

- Downstream consumer of the DHT11 ASCII digit stage.
- Snapshots temperature/humidity ASCII digits and sign.
- Serialises them as a fixed-format text line, byte by byte, over a valid/ready stream into the UART transmitter.
- Frames start periodically from an internal timer or on an explicit request, so readings reach a host terminal.

## Interface
Parameters:
- PERIOD_CYC, 50_000_000, cycles between timer-triggered frames (1 s at 50 MHz); 0 disables the timer.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- start  in  1  single-cycle frame request.
- sign  in  1  1 = negative temperature.
- temp_d3, temp_d2, temp_d1  in  8 each  temperature tens, units and tenths ASCII digits.
- hum_d3, hum_d2, hum_d1  in  8 each  humidity tens, units and tenths ASCII digits.
- tx_data  out  8  byte to UART.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  UART accepts byte.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after the last byte is accepted.

## Operation
- Frame layout: "T=" S T3 T2 "." T1 " H=" H3 H2 "." H1 "%" CR LF, giving 17 bytes.
- S is '-' (0x2D) when sign=1, else '+' (0x2B).
- Any snapshotted digit outside 0x30..0x39 is sent as '?' (0x3F).
- Trigger = start OR timer tick.
- Timer: a 32-bit counter runs 0..PERIOD_CYC-1 continuously from reset. The tick is asserted for one cycle on wrap.
- State machine, IDLE -> LOAD -> SEND -> DONE:
  - IDLE: busy=0, tx_valid=0. A trigger moves to LOAD.
  - LOAD: latch all seven inputs into shadow registers and clear the byte index. Go to SEND.
  - SEND: tx_valid=1, tx_data=byte[index].
    - A transfer occurs on a cycle with tx_valid & tx_ready. Each transfer increments index.
    - The transfer of the last byte goes to DONE.
    - Without a transfer, tx_data holds and tx_valid stays high.
  - DONE: frame_done=1 for one cycle. Go to LOAD if pending=1 (clearing pending), else IDLE.
- pending flag:
  - Set by a trigger seen in LOAD, SEND or DONE. Only one frame is queued; further triggers are dropped.
  - A simultaneous start and timer tick count as one trigger.
- Inputs changing mid-frame do not affect the frame in flight (shadow copy only).
- Reset mid-frame: the frame is abandoned immediately, and no partial continuation occurs after release.

## Timing
Reset values:
- tx_data=0x00, tx_valid=0, busy=0, frame_done=0.
- State IDLE, pending=0, index=0, timer=0.

Latency:
- Trigger sampled at edge k: LOAD after k; tx_valid=1 with 'T' after edge k+1.
- busy=1 from LOAD through DONE inclusive.

Throughput and handshake:
- With tx_ready held high, one byte per cycle.
- A 17-byte frame occupies 1 (LOAD) + 17 + 1 (DONE) cycles.
- tx_valid never deasserts before its byte is accepted.
- tx_data changes only on the cycle after a transfer.
- All outputs are registered.

## Configuration
- FRAME_CHECKSUM_EN, defined:
  - Two uppercase hex ASCII characters are inserted before CR LF, high nibble first.
  - They encode the XOR of all bytes from 'T' through '%' (15 bytes), after '?' substitution.
  - The frame is 19 bytes.
- FRAME_CHECKSUM_EN undefined: the 17-byte frame only, with no checksum logic.

## Test plan
- Send a 25.3 °C / 61.0 % reading:
  - Stimulus: sign=0; temp "2","5","3"; hum "6","1","0"; start pulse; tx_ready=1.
  - Without the macro: exactly "T=+25.3 H=61.0%\r\n", 17 consecutive cycles of tx_valid, then a frame_done pulse.
  - With FRAME_CHECKSUM_EN: "…%31\r\n", 19 bytes.
- Negative temperature and invalid digit: sign=1, temp_d2=0x41 -> third byte 0x2D, fifth byte 0x3F.
- Back-pressure: toggle tx_ready 1-in-3 -> tx_data stable and tx_valid high while tx_ready=0; byte sequence identical to the free-running case.
- Queuing and snapshot:
  - Stimulus: a start during SEND, another start during the same frame, and temp_d1 changed mid-frame.
  - Current frame keeps the old digit.
  - Exactly one more frame follows; it carries the new digit and starts LOAD on the cycle after frame_done.
- Timer: PERIOD_CYC=100, start held 0 -> a frame starts every 100 cycles; a simultaneous start and tick yields one frame.
- Reset: assert sys_rst_n=0 at byte 8 -> all outputs return to reset values immediately; no bytes appear until the next trigger after release.
